// File: rtl/polaris_bus_pkg.sv
// Shared definitions for the Polaris CPU bus: arbiter state encoding, port ids,
// transfer size codes and the read-lane selector used by the instruction port.
package polaris_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IGNT = 2'd1,
        ST_DGNT = 2'd2
    } bus_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } bus_port_e;

    localparam logic [1:0] SIZ_BYTE  = 2'd0;
    localparam logic [1:0] SIZ_HALF  = 2'd1;
    localparam logic [1:0] SIZ_WORD  = 2'd2;
    localparam logic [1:0] SIZ_DWORD = 2'd3;

    localparam int WDOG_W = 8;

    // Instruction words live in either half of the 64-bit bus, picked by address bit 2.
    function automatic logic [31:0] lane_select(input logic upper, input logic [63:0] data);
        return upper ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Grant watchdog: counts granted cycles without an acknowledge and flags
// expiry once TIMEOUT such cycles have elapsed.
module bus_watchdog
    import polaris_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LIMIT    = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] CNT_ZERO = {WDOG_W{1'b0}};
    localparam logic [WDOG_W-1:0] CNT_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic [WDOG_W-1:0] count_r;

    // Wait-cycle counter; saturates at the limit so expiry stays stable.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (enable && !expire) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single shared bus with
// alternating tie-break, request-drop abort and watchdog-forced termination.
module bus_arbiter
    import polaris_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [63:0] iadr_i,
    input  logic [1:0]  isiz_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    input  logic        dwe_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic [63:0] badr_o,
    output logic [63:0] bdat_o,
    output logic        bwe_o,
    output logic        bcyc_o,
    output logic        bstb_o,
    output logic [1:0]  bsiz_o,
    output logic        bsigned_o,
    input  logic        back_i,
    input  logic [63:0] bdat_i
);

    bus_state_e  state_r, state_nxt_s;
    bus_port_e   last_r, last_nxt_s;

    logic        ireq_s, dreq_s;
    logic        granted_s, expire_s, done_s;

    logic [63:0] badr_r, badr_nxt_s;
    logic [63:0] bdat_r, bdat_nxt_s;
    logic        bwe_r, bwe_nxt_s;
    logic        bcyc_r, bcyc_nxt_s;
    logic [1:0]  bsiz_r, bsiz_nxt_s;
    logic        bsigned_r, bsigned_nxt_s;

    assign ireq_s    = (isiz_i != 2'd0);
    assign dreq_s    = dcyc_i & dstb_i;
    assign granted_s = (state_r != ST_IDLE);
    assign done_s    = granted_s & (back_i | expire_s);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear    (~granted_s),
        .enable   (granted_s & ~back_i),
        .expire   (expire_s)
    );

    // Arbitration and grant lifetime; last_r only moves when a grant completes with an ack.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (ireq_s && dreq_s) begin
                    state_nxt_s = (last_r == PORT_D) ? ST_IGNT : ST_DGNT;
                end else if (dreq_s) begin
                    state_nxt_s = ST_DGNT;
                end else if (ireq_s) begin
                    state_nxt_s = ST_IGNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IGNT: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = PORT_I;
                end else if (!ireq_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_IGNT;
                end
            end
            ST_DGNT: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = PORT_D;
                end else if (!dreq_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DGNT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus values for the state being entered, so the registered outputs line up with it.
    always_comb begin
        badr_nxt_s    = 64'd0;
        bdat_nxt_s    = 64'd0;
        bwe_nxt_s     = 1'b0;
        bcyc_nxt_s    = 1'b0;
        bsiz_nxt_s    = SIZ_BYTE;
        bsigned_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IGNT: begin
                badr_nxt_s = iadr_i;
                bsiz_nxt_s = isiz_i;
                bcyc_nxt_s = 1'b1;
            end
            ST_DGNT: begin
                badr_nxt_s    = dadr_i;
                bdat_nxt_s    = dwe_i ? ddat_i : 64'd0;
                bwe_nxt_s     = dwe_i;
                bsiz_nxt_s    = dsiz_i;
                bsigned_nxt_s = dsigned_i;
                bcyc_nxt_s    = 1'b1;
            end
            ST_IDLE: begin
                bcyc_nxt_s = 1'b0;
            end
            default: begin
                bcyc_nxt_s = 1'b0;
            end
        endcase
    end

    // State, tie-break memory and registered bus outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r   <= ST_IDLE;
            last_r    <= PORT_I;
            badr_r    <= 64'd0;
            bdat_r    <= 64'd0;
            bwe_r     <= 1'b0;
            bcyc_r    <= 1'b0;
            bsiz_r    <= SIZ_BYTE;
            bsigned_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            last_r    <= last_nxt_s;
            badr_r    <= badr_nxt_s;
            bdat_r    <= bdat_nxt_s;
            bwe_r     <= bwe_nxt_s;
            bcyc_r    <= bcyc_nxt_s;
            bsiz_r    <= bsiz_nxt_s;
            bsigned_r <= bsigned_nxt_s;
        end
    end

    assign badr_o    = badr_r;
    assign bdat_o    = bdat_r;
    assign bwe_o     = bwe_r;
    assign bcyc_o    = bcyc_r;
    assign bstb_o    = bcyc_r;
    assign bsiz_o    = bsiz_r;
    assign bsigned_o = bsigned_r;

    // A watchdog-forced ack carries zero data unless the bus acked in the same cycle.
    assign iack_o = (state_r == ST_IGNT) & (back_i | expire_s);
    assign dack_o = (state_r == ST_DGNT) & (back_i | expire_s);
    assign idat_o = (iack_o && back_i) ? lane_select(badr_r[2], bdat_i) : 32'd0;
    assign ddat_o = (dack_o && back_i) ? bdat_i : 64'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic compared against a cycle-level reference model.
module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [63:0] iadr_i = 64'd0;
    logic [1:0]  isiz_i = 2'd0;
    logic        iack_o;
    logic [31:0] idat_o;
    logic [63:0] dadr_i = 64'd0;
    logic [63:0] ddat_i = 64'd0;
    logic        dwe_i = 1'b0;
    logic        dcyc_i = 1'b0;
    logic        dstb_i = 1'b0;
    logic [1:0]  dsiz_i = 2'd0;
    logic        dsigned_i = 1'b0;
    logic        dack_o;
    logic [63:0] ddat_o;
    logic [63:0] badr_o;
    logic [63:0] bdat_o;
    logic        bwe_o;
    logic        bcyc_o;
    logic        bstb_o;
    logic [1:0]  bsiz_o;
    logic        bsigned_o;
    logic        back_i = 1'b0;
    logic [63:0] bdat_i = 64'd0;

    always #5 clk_i = ~clk_i;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o),
        .dadr_i(dadr_i), .ddat_i(ddat_i), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
        .dstb_i(dstb_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
        .dack_o(dack_o), .ddat_o(ddat_o),
        .badr_o(badr_o), .bdat_o(bdat_o), .bwe_o(bwe_o), .bcyc_o(bcyc_o),
        .bstb_o(bstb_o), .bsiz_o(bsiz_o), .bsigned_o(bsigned_o),
        .back_i(back_i), .bdat_i(bdat_i)
    );

    typedef struct packed {
        logic [1:0]  isiz;
        logic [63:0] iadr;
        logic        dreq;
        logic        dwe;
        logic        dsg;
        logic [63:0] dadr;
        logic [63:0] ddat;
        logic [1:0]  dsiz;
        logic        back;
        logic [63:0] bdat;
    } ins_t;

    typedef struct packed {
        logic        iack;
        logic [31:0] idat;
        logic        dack;
        logic [63:0] ddat;
        logic [63:0] badr;
        logic [63:0] bdat;
        logic        bwe;
        logic        bcyc;
        logic        bstb;
        logic [1:0]  bsiz;
        logic        bsigned;
    } outs_t;

    typedef struct packed {
        ins_t  in;
        outs_t exp;
    } vec_t;

    int tests = 0;
    int fails = 0;

    function automatic ins_t mk_in(logic [1:0] isiz, logic [63:0] iadr, logic dreq, logic dwe,
                                   logic dsg, logic [63:0] dadr, logic [63:0] ddat,
                                   logic [1:0] dsiz, logic back, logic [63:0] bdat);
        ins_t x;
        x.isiz = isiz; x.iadr = iadr; x.dreq = dreq; x.dwe = dwe; x.dsg = dsg;
        x.dadr = dadr; x.ddat = ddat; x.dsiz = dsiz; x.back = back; x.bdat = bdat;
        return x;
    endfunction

    function automatic outs_t o_bus(logic cyc, logic [63:0] adr, logic [63:0] wd, logic we,
                                    logic [1:0] siz, logic sg);
        outs_t o;
        o = '0;
        o.bcyc = cyc; o.bstb = cyc; o.badr = adr; o.bdat = wd;
        o.bwe = we; o.bsiz = siz; o.bsigned = sg;
        return o;
    endfunction

    function automatic outs_t o_ack(outs_t b, logic ia, logic [31:0] id, logic da, logic [63:0] dd);
        outs_t o;
        o = b;
        o.iack = ia; o.idat = id; o.dack = da; o.ddat = dd;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.iack = iack_o; o.idat = idat_o; o.dack = dack_o; o.ddat = ddat_o;
        o.badr = badr_o; o.bdat = bdat_o; o.bwe = bwe_o; o.bcyc = bcyc_o;
        o.bstb = bstb_o; o.bsiz = bsiz_o; o.bsigned = bsigned_o;
        return o;
    endfunction

    task automatic drive(input ins_t x);
        isiz_i = x.isiz; iadr_i = x.iadr;
        dcyc_i = x.dreq; dstb_i = x.dreq; dwe_i = x.dwe; dsigned_i = x.dsg;
        dadr_i = x.dadr; ddat_i = x.ddat; dsiz_i = x.dsiz;
        back_i = x.back; bdat_i = x.bdat;
    endtask

    task automatic check(input string nm, input outs_t e);
        outs_t g;
        g = sample();
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, g, e);
        end
    endtask

    task automatic cyc(input ins_t x, input string nm, input outs_t e);
        @(negedge clk_i);
        drive(x);
        #1;
        check(nm, e);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_ni = 1'b0;
        drive('0);
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    // Reference model: which port holds the bus, how long it has waited, who won last.
    int    m_gnt;    // 0 none, 1 instruction, 2 data
    int    m_wait;
    bit    m_last_d;
    outs_t m_bus;

    function automatic outs_t model_eval(ins_t x);
        outs_t e;
        bit    fin;
        e = m_bus;
        fin = x.back || (m_wait == TO);
        e.iack = (m_gnt == 1) && fin;
        e.dack = (m_gnt == 2) && fin;
        e.idat = (e.iack && x.back) ? (m_bus.badr[2] ? x.bdat[63:32] : x.bdat[31:0]) : 32'd0;
        e.ddat = (e.dack && x.back) ? x.bdat : 64'd0;
        return e;
    endfunction

    task automatic model_step(input ins_t x);
        bit ireq, dreq, fin;
        int ng;
        ireq = (x.isiz != 2'd0);
        dreq = x.dreq;
        fin  = (m_gnt != 0) && (x.back || (m_wait == TO));
        if (m_gnt == 0) begin
            if (ireq && dreq) ng = m_last_d ? 1 : 2;
            else if (dreq)    ng = 2;
            else if (ireq)    ng = 1;
            else              ng = 0;
        end else if (fin) begin
            ng = 0;
            m_last_d = (m_gnt == 2);
        end else if ((m_gnt == 1 && !ireq) || (m_gnt == 2 && !dreq)) begin
            ng = 0;
        end else begin
            ng = m_gnt;
        end
        m_wait = (m_gnt != 0 && ng == m_gnt) ? m_wait + 1 : 0;
        if (ng == 1)      m_bus = o_bus(1'b1, x.iadr, 64'd0, 1'b0, x.isiz, 1'b0);
        else if (ng == 2) m_bus = o_bus(1'b1, x.dadr, x.dwe ? x.ddat : 64'd0, x.dwe, x.dsiz, x.dsg);
        else              m_bus = '0;
        m_gnt = ng;
    endtask

    vec_t  tbl[$];
    ins_t  none_in, fi, st, ab, tm, both, dr, ir, x;
    outs_t idle_o, fb, sb, ab_b, tb_b, db, ib, rb, e;
    bit    ion, don;

    initial begin
        none_in = '0;
        idle_o  = '0;
        fi   = mk_in(2'd2, 64'h1004, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0, 64'd0);
        fb   = o_bus(1'b1, 64'h1004, 64'd0, 1'b0, 2'd2, 1'b0);
        st   = mk_in(2'd0, 64'd0, 1'b1, 1'b1, 1'b0, 64'h2000, 64'h55, 2'd3, 1'b0, 64'd0);
        sb   = o_bus(1'b1, 64'h2000, 64'h55, 1'b1, 2'd3, 1'b0);
        ab   = mk_in(2'd2, 64'h3000, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0, 64'd0);
        ab_b = o_bus(1'b1, 64'h3000, 64'd0, 1'b0, 2'd2, 1'b0);
        tm   = mk_in(2'd0, 64'd0, 1'b1, 1'b0, 1'b1, 64'h4000, 64'h77, 2'd2, 1'b0, 64'd0);
        tb_b = o_bus(1'b1, 64'h4000, 64'd0, 1'b0, 2'd2, 1'b1);

        // Directed table: fetch, store, abort, back_i while idle, watchdog timeout.
        tbl.push_back('{fi, idle_o});
        tbl.push_back('{fi, fb});
        tbl.push_back('{fi, fb});
        x = fi; x.back = 1'b1; x.bdat = 64'hAAAA_BBBB_CCCC_DDDD;
        tbl.push_back('{x, o_ack(fb, 1'b1, 32'hAAAABBBB, 1'b0, 64'd0)});
        tbl.push_back('{none_in, idle_o});
        tbl.push_back('{st, idle_o});
        tbl.push_back('{st, sb});
        x = st; x.back = 1'b1; x.bdat = 64'h1234;
        tbl.push_back('{x, o_ack(sb, 1'b0, 32'd0, 1'b1, 64'h1234)});
        tbl.push_back('{none_in, idle_o});
        tbl.push_back('{ab, idle_o});
        tbl.push_back('{ab, ab_b});
        x = ab; x.isiz = 2'd0;
        tbl.push_back('{x, ab_b});
        x.back = 1'b1; x.bdat = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl.push_back('{x, idle_o});
        tbl.push_back('{tm, idle_o});
        for (int i = 0; i < TO; i++) tbl.push_back('{tm, tb_b});
        x = tm; x.bdat = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl.push_back('{x, o_ack(tb_b, 1'b0, 32'd0, 1'b1, 64'd0)});
        tbl.push_back('{none_in, idle_o});

        // Outputs while held in reset, even with requests and back_i present.
        drive(fi);
        back_i = 1'b1;
        #1;
        check("reset_state", idle_o);
        do_reset();

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i].in, $sformatf("vec[%0d]", i), tbl[i].exp);

        // Tie from reset: data wins, one idle cycle, then instruction.
        do_reset();
        both = mk_in(2'd2, 64'h1000, 1'b1, 1'b0, 1'b0, 64'h2000, 64'h0, 2'd1, 1'b0, 64'd0);
        db = o_bus(1'b1, 64'h2000, 64'd0, 1'b0, 2'd1, 1'b0);
        ib = o_bus(1'b1, 64'h1000, 64'd0, 1'b0, 2'd2, 1'b0);
        cyc(both, "tie_idle", idle_o);
        cyc(both, "tie_dgnt", db);
        x = both; x.back = 1'b1; x.bdat = 64'h0123_4567_89AB_CDEF;
        cyc(x, "tie_dack", o_ack(db, 1'b0, 32'd0, 1'b1, 64'h0123_4567_89AB_CDEF));
        cyc(both, "tie_gap", idle_o);
        cyc(both, "tie_ignt", ib);
        cyc(x, "tie_iack", o_ack(ib, 1'b1, 32'h89ABCDEF, 1'b0, 64'd0));
        cyc(none_in, "tie_end", idle_o);

        // Reset during a data grant: immediate idle, no ack, pending fetch granted after release.
        dr = mk_in(2'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'h5000, 64'd0, 2'd3, 1'b0, 64'd0);
        rb = o_bus(1'b1, 64'h5000, 64'd0, 1'b0, 2'd3, 1'b0);
        ir = mk_in(2'd2, 64'h6000, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0, 64'd0);
        cyc(dr, "rst_req", idle_o);
        cyc(dr, "rst_dgnt", rb);
        @(negedge clk_i);
        x = dr; x.back = 1'b1; x.bdat = 64'h42;
        drive(x);
        #1;
        check("rst_live_grant", o_ack(rb, 1'b0, 32'd0, 1'b1, 64'h42));
        #1;
        reset_ni = 1'b0;
        drive(ir);
        back_i = 1'b1;
        #1;
        check("rst_async", idle_o);
        @(negedge clk_i);
        reset_ni = 1'b1;
        drive(ir);
        #1;
        check("rst_release", idle_o);
        cyc(ir, "rst_ignt", o_bus(1'b1, 64'h6000, 64'd0, 1'b0, 2'd2, 1'b0));
        cyc(none_in, "rst_abort", o_bus(1'b1, 64'h6000, 64'd0, 1'b0, 2'd2, 1'b0));
        cyc(none_in, "rst_end", idle_o);

        // Randomized traffic against the reference model.
        do_reset();
        m_gnt = 0; m_wait = 0; m_last_d = 1'b0; m_bus = '0;
        ion = 1'b0; don = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 15) ion = ~ion;
            if ($urandom_range(0, 99) < 15) don = ~don;
            x.isiz = ion ? 2'($urandom_range(1, 3)) : 2'd0;
            x.iadr = {$urandom, $urandom};
            x.dreq = don;
            x.dwe  = 1'($urandom_range(0, 1));
            x.dsg  = 1'($urandom_range(0, 1));
            x.dadr = {$urandom, $urandom};
            x.ddat = {$urandom, $urandom};
            x.dsiz = 2'($urandom_range(0, 3));
            x.back = ($urandom_range(0, 99) < 20);
            x.bdat = {$urandom, $urandom};
            @(negedge clk_i);
            drive(x);
            #1;
            e = model_eval(x);
            check($sformatf("rand[%0d]", k), e);
            model_step(x);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
